// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: funct3 encodings, status bit positions, FSM states.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam int ST_Z = 0;
  localparam int ST_V = 1;
  localparam int ST_N = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational RV32 branch condition from funct3 and ALU {N,V,Z} status of rs1-rs2.
// Unsigned compares (BLTU/BGEU) use the ALU carry only when UNSIGNED_BRANCH_EN is defined.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [2:0] i_status,
`ifdef UNSIGNED_BRANCH_EN
  input  logic       i_carry,
`endif
  output logic       o_taken,
  output logic       o_illegal
);

  logic w_lt;
  assign w_lt = i_status[ST_N] ^ i_status[ST_V];

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      BEQ:  o_taken = i_status[ST_Z];
      BNE:  o_taken = !i_status[ST_Z];
      BLT:  o_taken = w_lt;
      BGE:  o_taken = !w_lt;
`ifdef UNSIGNED_BRANCH_EN
      // carry set means no borrow, i.e. rs1 >= rs2 unsigned
      BLTU: o_taken = !i_carry;
      BGEU: o_taken = i_carry;
`endif
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch decision stage: one branch per handshake, registered result held until consumed, then a
// FLUSH_CYCLES-long flush on taken. Optional unsigned compares via UNSIGNED_BRANCH_EN (adds carry port).
module branch_resolver
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [2:0]       status,
`ifdef UNSIGNED_BRANCH_EN
  input  logic             carry,
`endif
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [31:0]      target,
  output logic             illegal,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_flush_cnt;
  logic              r_taken;
  logic              r_illegal;
  logic [31:0]       r_target;
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_taken;
  logic              w_illegal;
  logic [31:0]       w_target;
  logic              w_accept;
  logic              w_consume;

  branch_cond u_cond (
    .i_funct3  (funct3),
    .i_status  (status),
`ifdef UNSIGNED_BRANCH_EN
    .i_carry   (carry),
`endif
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  assign w_target  = w_taken ? (pc + imm) : (pc + 32'd4);
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_consume = (r_state == HOLD) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = HOLD;
      HOLD:    if (out_ready) w_next = r_taken ? FLUSH : IDLE;
      FLUSH:   if (r_flush_cnt == 4'd1) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
      r_target    <= 32'd0;
      r_flush_cnt <= 4'd0;
    end else begin
      if (w_accept) begin
        r_taken   <= w_taken;
        r_illegal <= w_illegal;
        r_target  <= w_target;
      end
      if (w_consume && r_taken)
        r_flush_cnt <= FLUSH_INIT;
      else if (r_state == FLUSH)
        r_flush_cnt <= r_flush_cnt - 4'd1;
    end
  end

  // Performance counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (w_consume) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (r_taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == HOLD);
  assign flush      = (r_state == FLUSH);
  assign taken      = r_taken;
  assign illegal    = r_illegal;
  assign target     = r_target;
  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: vector table through full handshakes, plus backpressure and reset-in-flush.
module tb_branch_resolver;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int NVEC = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    funct3;
  logic [2:0]    status;
`ifdef UNSIGNED_BRANCH_EN
  logic          carry;
`endif
  logic [31:0]   pc;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic          taken;
  logic [31:0]   target;
  logic          illegal;
  logic          flush;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] taken_cnt;

  branch_resolver #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .status     (status),
`ifdef UNSIGNED_BRANCH_EN
    .carry      (carry),
`endif
    .pc         (pc),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .target     (target),
    .illegal    (illegal),
    .flush      (flush),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [2:0]  st;
    logic        cy;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        e_taken;
    logic        e_illegal;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs [NVEC];
  int   checks = 0;
  int   errors = 0;
  int   m_branches = 0;
  int   m_takens = 0;

  function automatic vec_t mk(input logic [2:0] f3, input logic [2:0] st, input logic cy,
                              input logic [31:0] p, input logic [31:0] im,
                              input logic et, input logic ei, input logic [31:0] etg);
    vec_t v;
    v.f3 = f3; v.st = st; v.cy = cy; v.pc = p; v.imm = im;
    v.e_taken = et; v.e_illegal = ei; v.e_target = etg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string name);
    int eb;
    int et;
    eb = (m_branches > 15) ? 15 : m_branches;
    et = (m_takens > 15) ? 15 : m_takens;
    chk({name, " branch_cnt"}, 32'(branch_cnt), 32'(eb));
    chk({name, " taken_cnt"}, 32'(taken_cnt), 32'(et));
  endtask

  // Offer one branch at a negedge; returns just after the accepting posedge with the result visible
  task automatic offer(input vec_t v);
    @(negedge clk);
    chk("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    funct3 = v.f3; status = v.st; pc = v.pc; imm = v.imm;
`ifdef UNSIGNED_BRANCH_EN
    carry = v.cy;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("out_valid after accept", 32'(out_valid), 32'd1);
    chk("in_ready in hold", 32'(in_ready), 32'd0);
    chk("taken", 32'(taken), 32'(v.e_taken));
    chk("illegal", 32'(illegal), 32'(v.e_illegal));
    chk("target", target, v.e_target);
  endtask

  // Consume the held result and walk through any flush window
  task automatic consume(input logic exp_taken);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_branches++;
    if (exp_taken) m_takens++;
    chk_counters("after consume");
    if (exp_taken) begin
      for (int i = 0; i < FC; i++) begin
        chk("flush high", 32'(flush), 32'd1);
        chk("out_valid in flush", 32'(out_valid), 32'd0);
        chk("in_ready in flush", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk("flush low after", 32'(flush), 32'd0);
    chk("in_ready back", 32'(in_ready), 32'd1);
    chk("out_valid low", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = 3'd0; status = 3'd0; pc = 32'd0; imm = 32'd0;
`ifdef UNSIGNED_BRANCH_EN
    carry = 1'b0;
`endif

    vecs[0]  = mk(3'b000, 3'b001, 1'b0, 32'h0000_0100, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0120);
    vecs[1]  = mk(3'b100, 3'b110, 1'b0, 32'h0000_0200, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0204);
    vecs[2]  = mk(3'b000, 3'b001, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0010);
    vecs[3]  = mk(3'b010, 3'b001, 1'b0, 32'h0000_0300, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0304);
    vecs[4]  = mk(3'b011, 3'b000, 1'b0, 32'h0000_0400, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0404);
    vecs[5]  = mk(3'b001, 3'b001, 1'b0, 32'h0000_0500, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0504);
    vecs[6]  = mk(3'b001, 3'b000, 1'b0, 32'h0000_0500, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0000_04F0);
    vecs[7]  = mk(3'b100, 3'b100, 1'b0, 32'h0000_0600, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0700);
    vecs[8]  = mk(3'b101, 3'b100, 1'b0, 32'h0000_0600, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0604);
    vecs[9]  = mk(3'b101, 3'b010, 1'b0, 32'h0000_0700, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0704);
    vecs[10] = mk(3'b101, 3'b000, 1'b0, 32'h0000_0800, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_080C);
    vecs[11] = mk(3'b000, 3'b000, 1'b0, 32'h0000_0900, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0904);
`ifdef UNSIGNED_BRANCH_EN
    vecs[12] = mk(3'b110, 3'b000, 1'b0, 32'h0000_0A00, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0A10);
    vecs[13] = mk(3'b111, 3'b000, 1'b1, 32'h0000_0B00, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0B10);
`else
    vecs[12] = mk(3'b110, 3'b000, 1'b0, 32'h0000_0A00, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0A04);
    vecs[13] = mk(3'b111, 3'b000, 1'b1, 32'h0000_0B00, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0B04);
`endif
    vecs[14] = mk(3'b000, 3'b000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0000);

    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset taken", 32'(taken), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset target", target, 32'd0);
    chk_counters("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      offer(vecs[i]);
      consume(vecs[i].e_taken);
    end

    // Backpressure: BNE taken held for five stalled cycles
    offer(mk(3'b001, 3'b000, 1'b0, 32'h0000_1000, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_1040));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp taken", 32'(taken), 32'd1);
      chk("bp target", target, 32'h0000_1040);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    consume(1'b1);

    // Reset asserted mid-flush takes effect without a clock edge
    offer(vecs[0]);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pre-reset flush", 32'(flush), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset flush", 32'(flush), 32'd0);
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    m_branches = 0;
    m_takens = 0;
    chk_counters("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    // One more branch after reset to confirm a clean restart
    offer(vecs[1]);
    consume(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer of the ALU's {NEGATIVE, OVERFLOW, ZERO} status word. The ALU executes the branch compare as a SUB, and this block turns that status into a branch decision.
- Accepts one branch per valid/ready handshake, evaluates the RV32 branch condition from funct3, and computes the next PC (pc+imm or pc+4).
- Presents the result registered to the fetch stage and drives a multi-cycle pipeline flush on a taken branch.
- Sits between the execute stage (ALU) and the PC/fetch logic.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held high after a taken branch is consumed; legal range 1..15.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage offers a branch.
- in_ready  out  1  block can accept a branch.
- funct3  in  3  RV32 branch funct3.
- status  in  3  ALU status {N,V,Z} for rs1-rs2.
- pc  in  32  branch instruction address.
- imm  in  32  sign-extended B-immediate.
- out_valid  out  1  decision available.
- out_ready  in  1  fetch stage consumes the decision.
- taken  out  1  branch taken.
- target  out  32  next PC.
- illegal  out  1  funct3 unsupported.
- flush  out  1  squash younger instructions.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- taken_cnt  out  CNT_W  taken branches, saturating.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0 except in_ready, which is 1; state is IDLE; counters are 0. Reset mid-operation aborts any pending result or flush immediately.
- FSM states: IDLE, HOLD, FLUSH.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: capture the decision into the output registers and go to HOLD.
  - Latency: out_valid rises on the edge after acceptance.
- HOLD:
  - in_ready=0 and out_valid=1.
  - taken, target and illegal are stable until out_ready.
  - On out_valid&out_ready:
    - branch_cnt increments; taken_cnt increments if taken.
    - If taken: go to FLUSH and load the flush counter with FLUSH_CYCLES.
    - Otherwise: go to IDLE.
- FLUSH:
  - flush=1, in_ready=0, out_valid=0.
  - The counter decrements each cycle.
  - Return to IDLE after exactly FLUSH_CYCLES cycles of flush high.
- Conditions (N,V,Z from status[2],status[1],status[0]):
  - 000 BEQ: taken = Z.
  - 001 BNE: taken = !Z.
  - 100 BLT: taken = N^V.
  - 101 BGE: taken = !(N^V).
  - 110 BLTU / 111 BGEU: see Optional Feature.
  - 010, 011: illegal=1, taken=0.
- Target arithmetic:
  - taken: target = pc+imm, modulo 2^32 (wrap-around, no trap).
  - not taken or illegal: target = pc+4, modulo 2^32.
  - Bit 1:0 misalignment is not checked.
- Counters saturate at all-ones; no wrap.
- There is no accept in the same cycle as out_ready; throughput is one branch per 2 cycles (not taken) or 2+FLUSH_CYCLES cycles (taken).

Optional Feature:
- Macro: UNSIGNED_BRANCH_EN.
- Defined:
  - Adds input port carry (1 bit): ALU carry-out of rs1+~rs2+1.
  - BLTU: taken = !carry.
  - BGEU: taken = carry.
- Undefined:
  - No carry port.
  - funct3 110/111 are treated as illegal (illegal=1, taken=0, target pc+4).

Decomposition:
- Shared package (branch_pkg):
  - funct3 localparams: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Status bit indices: ST_Z=0, ST_V=1, ST_N=2.
  - FSM state enum {IDLE, HOLD, FLUSH}.
- Sub-module branch_cond: purely combinational funct3+status(+carry) -> {taken, illegal}.
- branch_resolver holds the FSM, output registers, target adder, and counters.

Test Plan:
- Reset, then BEQ with status=001, pc=0x100, imm=0x20, out_ready=1:
  - out_valid one cycle after accept with taken=1, target=0x120.
  - flush high exactly 2 cycles.
  - branch_cnt=1, taken_cnt=1.
- BLT with status=110 (N=1, V=1), pc=0x200 -> taken=0, target=0x204, no flush, in_ready back to 1 the cycle after consume.
- Backpressure: out_ready=0 for 5 cycles after BNE status=000 -> out_valid, taken=1 and target held stable; in_ready=0 throughout.
- Wrap: pc=0xFFFFFFF0, imm=0x20, BEQ taken -> target=0x00000010.
- funct3=010 -> illegal=1, taken=0, target=pc+4. With UNSIGNED_BRANCH_EN: BLTU with carry=0 -> taken=1.
- Assert rst_n low during FLUSH -> flush=0, out_valid=0, in_ready=1, and counters 0 immediately, without waiting for a clock edge.
